// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer and the op decoder.
//   - default datapath / shift-count widths
//   - shifter op codes (ROL..RRC)
//   - sequencer FSM states
//   - decoded shifter control strobe bundle
package shift_sequencer_pkg;

    localparam int unsigned SEQ_W_DEFAULT     = 16;
    localparam int unsigned SEQ_CNT_W_DEFAULT = 4;

    typedef enum logic [2:0] {
        OP_ROL = 3'b000,
        OP_ROR = 3'b001,
        OP_ASL = 3'b010,
        OP_ASR = 3'b011,
        OP_LSL = 3'b100,
        OP_LSR = 3'b101,
        OP_RLC = 3'b110,
        OP_RRC = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Decoded shifter_module strobes (Ain..Ein, Rin, Lin)
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic r;
        logic l;
    } ctrl_t;

endpackage

// File: rtl/shift_sequencer_ctrl_dec.sv
// shifter_ctrl_dec: combinational op -> shifter_module strobe decoder.
// One truth table shared by the sequencer and the switch/LED board wrapper.
// Ports:
//   i_op    in  3  shift mode (ROL,ROR,ASL,ASR,LSL,LSR,RLC,RRC)
//   o_ctrl  out    decoded strobes {A,B,C,D,E,R,L}
module shifter_ctrl_dec
    import shift_sequencer_pkg::*;
(
    input  logic [2:0] i_op,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl   = '0;
        // Direction is carried purely by op bit 0: odd codes go right.
        o_ctrl.r = i_op[0];
        o_ctrl.l = ~i_op[0];
        case (i_op)
            OP_ROL: begin
                o_ctrl.b = 1'b1;
                o_ctrl.c = 1'b1;
            end
            OP_ROR: o_ctrl.d = 1'b1;
            OP_ASL,
            OP_ASR: o_ctrl.a = 1'b1;
            OP_LSL: o_ctrl.c = 1'b1;
            OP_RLC: begin
                o_ctrl.c = 1'b1;
                o_ctrl.e = 1'b1;
            end
            OP_RRC: o_ctrl.e = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: drives shifter_module for an N-step shift/rotate, feeding
// each single-step result back as the next operand.
// Ports:
//   clk, rst_n           clock (rising), async active-low reset
//   start                run request, sampled in IDLE only
//   op[2:0]              shift mode
//   count[CNT_W-1:0]     number of single-bit steps (0 = pass-through)
//   data_in[W-1:0]       initial operand
//   cf_in                initial carry
//   busy                 high from LOAD through DONE
//   done                 one-cycle pulse, result/cf_out valid
//   result[W-1:0]        final operand, held until next run
//   cf_out               final carry, held until next run
//   sh_rin..sh_ein,sh_shs  shifter_module strobes (SHIFT state only)
//   sh_a_bus[W-1:0]      operand to shifter_module A_bus
//   sh_result[W-1:0]     shifter_module result bus
//   sh_cf                shifter_module carry out
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned W     = SEQ_W_DEFAULT,
    parameter int unsigned CNT_W = SEQ_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic [W-1:0]     data_in,
    input  logic             cf_in,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic             cf_out,
    output logic             sh_rin,
    output logic             sh_lin,
    output logic             sh_ain,
    output logic             sh_bin,
    output logic             sh_cin,
    output logic             sh_din,
    output logic             sh_ein,
    output logic             sh_shs,
    output logic [W-1:0]     sh_a_bus,
    input  logic [W-1:0]     sh_result,
    input  logic             sh_cf
);

    state_e           r_state;
    state_e           w_next;
    logic [2:0]       r_op;
    logic [W-1:0]     r_work;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [W-1:0]     r_result;
    logic             r_cf_out;
    ctrl_t            w_ctrl;
    logic             w_shift;

    shifter_ctrl_dec u_dec (
        .i_op   (r_op),
        .o_ctrl (w_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // LOAD decides on the live count input because r_cnt is being loaded
    // on the same edge.
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_next = start ? ST_LOAD : ST_IDLE;
            ST_LOAD:  w_next = (count == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: w_next = (r_cnt == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // done is registered so it rises on the same edge that captures result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_work   <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cf_out <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op <= op;
                    end
                end
                ST_LOAD: begin
                    r_work  <= data_in;
                    r_carry <= cf_in;
                    r_cnt   <= count;
                end
                ST_SHIFT: begin
                    r_work  <= sh_result;
                    r_carry <= sh_cf;
                    r_cnt   <= r_cnt - CNT_W'(1);
                end
                ST_DONE: begin
                    r_result <= r_work;
                    r_cf_out <= r_carry;
                end
                default: ;
            endcase
        end
    end

    assign w_shift  = (r_state == ST_SHIFT);

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign result   = r_result;
    assign cf_out   = r_cf_out;

    assign sh_shs   = w_shift;
    assign sh_ain   = w_shift & w_ctrl.a;
    assign sh_bin   = w_shift & w_ctrl.b;
    assign sh_cin   = w_shift & w_ctrl.c & r_carry;
    assign sh_din   = w_shift & w_ctrl.d;
    assign sh_ein   = w_shift & w_ctrl.e;
    assign sh_rin   = w_shift & w_ctrl.r;
    assign sh_lin   = w_shift & w_ctrl.l;
    assign sh_a_bus = r_work;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer with a behavioural single-step shifter closing
// the loop. Expected results are pushed on issue; a monitor pops on done.
module tb_shift_sequencer;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic [3:0]    count;
    logic [W-1:0]  data_in;
    logic          cf_in;
    logic          busy, done, cf_out;
    logic [W-1:0]  result;
    logic          sh_rin, sh_lin, sh_ain, sh_bin, sh_cin, sh_din, sh_ein, sh_shs;
    logic [W-1:0]  sh_a_bus;
    logic [W-1:0]  sh_result;
    logic          sh_cf;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         cf;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];

    shift_sequencer #(.W(W), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .count     (count),
        .data_in   (data_in),
        .cf_in     (cf_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cf_out    (cf_out),
        .sh_rin    (sh_rin),
        .sh_lin    (sh_lin),
        .sh_ain    (sh_ain),
        .sh_bin    (sh_bin),
        .sh_cin    (sh_cin),
        .sh_din    (sh_din),
        .sh_ein    (sh_ein),
        .sh_shs    (sh_shs),
        .sh_a_bus  (sh_a_bus),
        .sh_result (sh_result),
        .sh_cf     (sh_cf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-step shifter model driven by the strobes.
    always_comb begin
        sh_result = sh_a_bus;
        sh_cf     = 1'b0;
        if (sh_shs) begin
            if (sh_ein) begin
                if (sh_lin) {sh_cf, sh_result} = {sh_a_bus, sh_cin};
                else        {sh_result, sh_cf} = {sh_cin, sh_a_bus};
            end else if (sh_bin) begin
                sh_result = {sh_a_bus[W-2:0], sh_a_bus[W-1]};
                sh_cf     = sh_a_bus[W-1];
            end else if (sh_din) begin
                sh_result = {sh_a_bus[0], sh_a_bus[W-1:1]};
                sh_cf     = sh_a_bus[0];
            end else if (sh_ain) begin
                if (sh_lin) begin
                    sh_result = {sh_a_bus[W-2:0], 1'b0};
                    sh_cf     = sh_a_bus[W-1];
                end else begin
                    sh_result = {sh_a_bus[W-1], sh_a_bus[W-1:1]};
                    sh_cf     = sh_a_bus[0];
                end
            end else begin
                if (sh_lin) begin
                    sh_result = {sh_a_bus[W-2:0], 1'b0};
                    sh_cf     = sh_a_bus[W-1];
                end else begin
                    sh_result = {1'b0, sh_a_bus[W-1:1]};
                    sh_cf     = sh_a_bus[0];
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("cf_out", 32'(cf_out), 32'(e.cf));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        check("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 32'(sb_q.size()), 32'(0));
    endtask

    // exp_strb order: {A,B,D,E,R,L}; exp_cin bit k = sh_cin on step k.
    task automatic run_op(input string tag, input logic [2:0] op_i, input logic [3:0] cnt_i,
                          input logic [W-1:0] d_i, input logic cf_i,
                          input logic [W-1:0] exp_res, input logic exp_cf,
                          input logic [5:0] exp_strb, input logic [15:0] exp_cin,
                          input int pulse_at);
        int c0;
        int nshs;
        int step;
        int stray;
        wait_idle();
        @(negedge clk);
        op = op_i; count = cnt_i; data_in = d_i; cf_in = cf_i; start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        sb_q.push_back('{res: exp_res, cf: exp_cf, cyc: c0 + int'(cnt_i) + 2});
        start = 1'b0;
        @(posedge clk);
        #1;
        op = ~op_i; count = ~cnt_i; data_in = ~d_i; cf_in = ~cf_i;
        nshs = 0; step = 0; stray = 0;
        for (int k = 0; k < int'(cnt_i) + 2; k++) begin
            @(negedge clk);
            if (k == pulse_at) begin
                start = 1'b1; op = 3'b000; data_in = 16'hFFFF; count = 4'd2;
            end else if (k == pulse_at + 1) begin
                start = 1'b0;
            end
            if (sh_shs) begin
                nshs++;
                check({tag, "_strobes"}, 32'({sh_ain, sh_bin, sh_din, sh_ein, sh_rin, sh_lin}),
                      32'(exp_strb));
                check({tag, "_cin"}, 32'(sh_cin), 32'(exp_cin[step]));
                step++;
            end else if (|{sh_ain, sh_bin, sh_cin, sh_din, sh_ein, sh_rin, sh_lin}) begin
                stray++;
            end
        end
        check({tag, "_shift_cycles"}, 32'(nshs), 32'(cnt_i));
        check({tag, "_stray_strobes"}, 32'(stray), 32'(0));
        drain();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        rst_n = 1'b0; start = 1'b0; op = '0; count = '0; data_in = '0; cf_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", 32'({busy, done, cf_out, sh_rin, sh_lin, sh_ain, sh_bin,
                                 sh_cin, sh_din, sh_ein, sh_shs}), 32'(0));
        check("reset_result", 32'(result), 32'(0));
        check("reset_a_bus", 32'(sh_a_bus), 32'(0));
        rst_n = 1'b1;

        // LSL 0x0001 by 4
        run_op("lsl", 3'b100, 4'd4, 16'h0001, 1'b0, 16'h0010, 1'b0, 6'b000001, 16'h0000, -10);

        // Reset mid-SHIFT (unscoreboarded run)
        wait_idle();
        @(negedge clk);
        op = 3'b100; count = 4'd10; data_in = 16'h00FF; cf_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy_shs", 32'({busy, sh_shs}), 32'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        check("abort_ctrl", 32'({busy, done, cf_out, sh_rin, sh_lin, sh_ain, sh_bin,
                                 sh_cin, sh_din, sh_ein, sh_shs}), 32'(0));
        check("abort_result", 32'(result), 32'(0));
        check("abort_a_bus", 32'(sh_a_bus), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_idle", 32'(busy), 32'(0));

        // ROR 0x0001 by 1
        run_op("ror", 3'b001, 4'd1, 16'h0001, 1'b0, 16'h8000, 1'b1, 6'b001010, 16'h0000, -10);

        // count = 0 pass-through
        run_op("cnt0", 3'b011, 4'd0, 16'hA5A5, 1'b1, 16'hA5A5, 1'b1, 6'b000000, 16'h0000, -10);

        // LSR 0x8000 by 15, start pulsed mid-run
        run_op("lsr15", 3'b101, 4'd15, 16'h8000, 1'b0, 16'h0001, 1'b0, 6'b000010, 16'h0000, 3);

        // RLC through carry
        run_op("rlc", 3'b110, 4'd2, 16'h8000, 1'b0, 16'h0001, 1'b0, 6'b000101, 16'h0002, -10);

        // start held high: back-to-back runs with one IDLE cycle between them
        wait_idle();
        @(negedge clk);
        op = 3'b000; count = 4'd1; data_in = 16'h8001; cf_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 c0 = cyc;
        sb_q.push_back('{res: 16'h0003, cf: 1'b1, cyc: c0 + 3});
        sb_q.push_back('{res: 16'h8000, cf: 1'b0, cyc: c0 + 7});
        @(posedge clk);
        #1 data_in = 16'h4000;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        check("final_queue_empty", 32'(sb_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
